// File: rtl/secded_decoder_if.sv
// Valid/ready stream bundle for the SECDED decoder: codeword in, decoded word and flags out.
// master = producer/consumer side, slave = the decoder.
interface secded_decoder_if #(
    parameter int DATA_W = 8
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int CODE_W = DATA_W + PAR_W + 1;
    localparam int POS_W  = $clog2(CODE_W);

    logic [CODE_W-1:0] in_code;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_sec;
    logic              out_ded;
    logic [POS_W-1:0]  out_err_pos;

    modport master (
        output in_code, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sec, out_ded, out_err_pos
    );

    modport slave (
        input  in_code, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sec, out_ded, out_err_pos
    );
endinterface

// File: rtl/secded_decoder.sv
// Parametrised SECDED Hamming decoder: two-stage valid/ready pipeline, optional
// single-error correction and saturating SEC/DED event counters.
module secded_decoder #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    secded_decoder_if.slave  bus,
    input  logic             correct_en,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_sec,
    output logic [CNT_W-1:0] cnt_ded
);
    function automatic int calc_par_w(input int dw);
        int r;
        r = 1;
        while ((1 << r) < (dw + r + 1)) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int PAR_W  = calc_par_w(DATA_W);
    localparam int N      = DATA_W + PAR_W;
    localparam int CODE_W = N + 1;
    localparam int POS_W  = $clog2(CODE_W);

    // Positions 1..N whose index has bit k set.
    function automatic logic [CODE_W-1:0] syn_mask(input int k);
        logic [CODE_W-1:0] m;
        m = '0;
        for (int i = 1; i < CODE_W; i++) begin
            m[i] = (((i >> k) & 1) == 1);
        end
        return m;
    endfunction

    // Codeword position of payload bit idx: the idx-th non-power-of-two position.
    function automatic int data_pos(input int idx);
        int pos;
        int seen;
        pos  = 2;
        seen = -1;
        while (seen < idx) begin
            pos = pos + 1;
            if ((pos & (pos - 1)) != 0) begin
                seen = seen + 1;
            end
        end
        return pos;
    endfunction

    logic              en;
    logic [PAR_W-1:0]  syn_next;
    logic [DATA_W-1:0] raw_next;

    logic              s1_valid_reg;
    logic [DATA_W-1:0] s1_raw_reg;
    logic [PAR_W-1:0]  s1_syn_reg;
    logic              s1_par_reg;
    logic              s1_mode_reg;

    logic              sec_next;
    logic              ded_next;
    logic              flip_next;
    logic [POS_W-1:0]  pos_next;
    logic [DATA_W-1:0] data_next;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_sec_reg;
    logic              out_ded_reg;
    logic [POS_W-1:0]  out_pos_reg;
    logic [CNT_W-1:0]  cnt_sec_reg;
    logic [CNT_W-1:0]  cnt_ded_reg;

    assign en           = !out_valid_reg | bus.out_ready;
    assign bus.in_ready = en;

    genvar gi;
    generate
        for (gi = 0; gi < PAR_W; gi++) begin : g_syn
            localparam logic [CODE_W-1:0] MASK = syn_mask(gi);
            assign syn_next[gi] = ^(bus.in_code & MASK);
        end
        // Stage 1 keeps only payload positions; a flipped parity bit never reaches the output.
        for (gi = 0; gi < DATA_W; gi++) begin : g_raw
            localparam int DP = data_pos(gi);
            assign raw_next[gi] = bus.in_code[DP];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_reg <= 1'b0;
            s1_raw_reg   <= '0;
            s1_syn_reg   <= '0;
            s1_par_reg   <= 1'b0;
            s1_mode_reg  <= 1'b0;
        end else if (en) begin
            s1_valid_reg <= bus.in_valid;
            s1_raw_reg   <= raw_next;
            s1_syn_reg   <= syn_next;
            s1_par_reg   <= ^bus.in_code;
            s1_mode_reg  <= correct_en;
        end
    end

    always_comb begin
        sec_next  = 1'b0;
        ded_next  = 1'b0;
        flip_next = 1'b0;
        pos_next  = '0;
        if (s1_par_reg) begin
            if (s1_syn_reg == '0) begin
                sec_next = 1'b1;
            end else if (s1_syn_reg <= PAR_W'(N)) begin
                sec_next  = 1'b1;
                pos_next  = POS_W'(s1_syn_reg);
                flip_next = s1_mode_reg;
            end else begin
                ded_next = 1'b1;
            end
        end else if (s1_syn_reg != '0) begin
            ded_next = 1'b1;
        end
    end

    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_fix
            localparam int DP = data_pos(gi);
            assign data_next[gi] = s1_raw_reg[gi] ^ (flip_next & (pos_next == POS_W'(DP)));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sec_reg   <= 1'b0;
            out_ded_reg   <= 1'b0;
            out_pos_reg   <= '0;
        end else if (en) begin
            out_valid_reg <= s1_valid_reg;
            out_data_reg  <= data_next;
            out_sec_reg   <= s1_valid_reg & sec_next;
            out_ded_reg   <= s1_valid_reg & ded_next;
            out_pos_reg   <= s1_valid_reg ? pos_next : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_sec_reg <= '0;
            cnt_ded_reg <= '0;
        end else if (clr_cnt) begin
            cnt_sec_reg <= '0;
            cnt_ded_reg <= '0;
        end else if (out_valid_reg && bus.out_ready) begin
            if (out_sec_reg && (cnt_sec_reg != '1)) begin
                cnt_sec_reg <= cnt_sec_reg + CNT_W'(1);
            end
            if (out_ded_reg && (cnt_ded_reg != '1)) begin
                cnt_ded_reg <= cnt_ded_reg + CNT_W'(1);
            end
        end
    end

    assign bus.out_valid   = out_valid_reg;
    assign bus.out_data    = out_data_reg;
    assign bus.out_sec     = out_sec_reg;
    assign bus.out_ded     = out_ded_reg;
    assign bus.out_err_pos = out_pos_reg;
    assign cnt_sec         = cnt_sec_reg;
    assign cnt_ded         = cnt_ded_reg;
endmodule

// File: tb/tb_secded_decoder.sv
// Self-checking bench for secded_decoder (DATA_W = 8): fixed vectors, stall, random
// stream against a positional-arithmetic reference model, counter saturation, mid-flight reset.
module tb_secded_decoder;
    typedef struct {
        logic [7:0] data;
        logic       sec;
        logic       ded;
        logic [3:0] pos;
    } res_t;

    logic        clk;
    logic        reset;
    logic        correct_en;
    logic        clr_cnt;
    logic [15:0] cnt_sec;
    logic [15:0] cnt_ded;
    logic        correct_en2;
    logic        clr_cnt2;
    logic [1:0]  cnt_sec2;
    logic [1:0]  cnt_ded2;

    int checks = 0;
    int errors = 0;
    int exp_sec = 0;
    int exp_ded = 0;

    secded_decoder_if #(.DATA_W(8)) bus ();
    secded_decoder_if #(.DATA_W(8)) bus2 ();

    secded_decoder #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .correct_en(correct_en), .clr_cnt(clr_cnt),
        .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
    );

    secded_decoder #(.DATA_W(8), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bus(bus2),
        .correct_en(correct_en2), .clr_cnt(clr_cnt2),
        .cnt_sec(cnt_sec2), .cnt_ded(cnt_ded2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Encoder: data fills non-power-of-two positions from 3 upward; parity at 2^k is even.
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        int k;
        logic par;
        c = '0;
        k = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++) begin
                if (((pos >> j) & 1) == 1 && pos != (1 << j)) par ^= c[pos];
            end
            c[1 << j] = par;
        end
        par = 1'b0;
        for (int pos = 1; pos <= 12; pos++) par ^= c[pos];
        c[0] = par;
        return c;
    endfunction

    // Reference decode: syndrome is the XOR of the indices of all set bits 1..12.
    function automatic res_t model(input logic [12:0] code, input logic mode);
        res_t r;
        int s;
        int p;
        int k;
        logic [12:0] c;
        s = 0;
        p = 0;
        for (int i = 0; i < 13; i++) begin
            if (code[i]) begin
                p ^= 1;
                if (i > 0) s ^= i;
            end
        end
        r.sec = 1'b0;
        r.ded = 1'b0;
        r.pos = 4'd0;
        c = code;
        if (p == 1 && s == 0) begin
            r.sec = 1'b1;
        end else if (p == 1 && s <= 12) begin
            r.sec = 1'b1;
            r.pos = 4'(s);
            if (mode) c[s] = ~c[s];
        end else if (s != 0) begin
            r.ded = 1'b1;
        end
        r.data = '0;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                r.data[k] = c[i];
                k++;
            end
        end
        return r;
    endfunction

    function automatic logic [12:0] gen_code();
        logic [12:0] c;
        logic [12:0] m;
        int n;
        c = enc(8'($urandom));
        if ($urandom_range(0, 7) == 0) return 13'($urandom);
        n = $urandom_range(0, 3);
        m = '0;
        while ($countones(m) < n) m[$urandom_range(0, 12)] = 1'b1;
        return c ^ m;
    endfunction

    task automatic run_word(input logic [12:0] code, input logic mode, output res_t r, output int lat);
        @(negedge clk);
        bus.in_code   = code;
        correct_en    = mode;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            lat++;
        end while (!bus.out_valid && lat < 8);
        r.data = bus.out_data;
        r.sec  = bus.out_sec;
        r.ded  = bus.out_ded;
        r.pos  = bus.out_err_pos;
    endtask

    task automatic test_reset();
        logic [14:0] outs;
        reset = 1'b0;
        correct_en = 1'b1;  clr_cnt = 1'b0;
        correct_en2 = 1'b1; clr_cnt2 = 1'b0;
        bus.in_code = '0;  bus.in_valid = 1'b0;  bus.out_ready = 1'b1;
        bus2.in_code = '0; bus2.in_valid = 1'b0; bus2.out_ready = 1'b1;
        #12;
        outs = {bus.out_valid, bus.out_sec, bus.out_ded, bus.out_err_pos, bus.out_data};
        checks++;
        if (outs !== 15'd0) begin errors++; $display("FAIL reset_outputs got=%0h exp=0", outs); end
        checks++;
        if ({cnt_sec, cnt_ded} !== 32'd0) begin errors++; $display("FAIL reset_counters got=%0h exp=0", {cnt_sec, cnt_ded}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_idle_valid got=%b exp=0", bus.out_valid); end
    endtask

    logic [12:0] v_code [0:6] = '{13'h144E, 13'h140E, 13'h140E, 13'h144F, 13'h1406, 13'h0448, 13'h044E};
    logic        v_mode [0:6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  v_data [0:6] = '{8'hA5, 8'hA5, 8'hA1, 8'hA5, 8'hA0, 8'h25, 8'hA5};
    logic        v_sec  [0:6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic        v_ded  [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0]  v_pos  [0:6] = '{4'd0, 4'd6, 4'd6, 4'd0, 4'd0, 4'd0, 4'd12};

    task automatic test_vectors();
        res_t r;
        int lat;
        for (int i = 0; i < 7; i++) begin
            run_word(v_code[i], v_mode[i], r, lat);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL vec%0d_latency got=%0d exp=2", i, lat); end
            checks++;
            if ({r.data, r.sec, r.ded, r.pos} !== {v_data[i], v_sec[i], v_ded[i], v_pos[i]})
            begin
                errors++;
                $display("FAIL vec%0d_decode got data=%0h sec=%b ded=%b pos=%0d exp data=%0h sec=%b ded=%b pos=%0d",
                         i, r.data, r.sec, r.ded, r.pos, v_data[i], v_sec[i], v_ded[i], v_pos[i]);
            end
            exp_sec += int'(v_sec[i]);
            exp_ded += int'(v_ded[i]);
            @(negedge clk);
            checks++;
            if (cnt_sec !== 16'(exp_sec) || cnt_ded !== 16'(exp_ded)) begin
                errors++;
                $display("FAIL vec%0d_counters got sec=%0d ded=%0d exp sec=%0d ded=%0d", i, cnt_sec, cnt_ded, exp_sec, exp_ded);
            end
        end
    endtask

    task automatic test_stall();
        res_t q[$];
        res_t e;
        int sent = 0;
        int got = 0;
        logic prev_stall = 1'b0;
        logic [14:0] prev_out = '0;
        logic [14:0] cur_out;
        for (int cyc = 0; cyc < 20 && got < 5; cyc++) begin
            @(negedge clk);
            cur_out = {bus.out_valid, bus.out_sec, bus.out_ded, bus.out_err_pos, bus.out_data};
            if (prev_stall) begin
                checks++;
                if (cur_out !== prev_out) begin errors++; $display("FAIL stall_hold cyc=%0d got=%0h exp=%0h", cyc, cur_out, prev_out); end
            end
            bus.out_ready = !(cyc >= 3 && cyc <= 5);
            if (sent < 5) begin
                bus.in_code  = gen_code();
                correct_en   = 1'($urandom);
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            checks++;
            if (bus.out_valid && !bus.out_ready) begin
                if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", cyc, bus.in_ready); end
            end else if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=1", cyc, bus.in_ready);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stall_extra_word got=%0h exp=none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_data, bus.out_sec, bus.out_ded, bus.out_err_pos} !== {e.data, e.sec, e.ded, e.pos}) begin
                        errors++;
                        $display("FAIL stall_word%0d got=%0h exp=%0h", got,
                                 {bus.out_data, bus.out_sec, bus.out_ded, bus.out_err_pos}, {e.data, e.sec, e.ded, e.pos});
                    end
                    exp_sec += int'(e.sec);
                    exp_ded += int'(e.ded);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_code, correct_en));
                sent++;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = cur_out;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got !== 5) begin errors++; $display("FAIL stall_delivered got=%0d exp=5", got); end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_duplicate got=%b exp=0", bus.out_valid); end
        end
        checks++;
        if (cnt_sec !== 16'(exp_sec) || cnt_ded !== 16'(exp_ded)) begin
            errors++; $display("FAIL stall_counters got sec=%0d ded=%0d exp sec=%0d ded=%0d", cnt_sec, cnt_ded, exp_sec, exp_ded);
        end
    endtask

    task automatic test_random(input int n);
        res_t q[$];
        res_t e;
        int sent = 0;
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < n * 20) begin
            @(negedge clk);
            cyc++;
            checks++;
            if (cnt_sec !== 16'(exp_sec) || cnt_ded !== 16'(exp_ded)) begin
                errors++; $display("FAIL rand_counters cyc=%0d got sec=%0d ded=%0d exp sec=%0d ded=%0d", cyc, cnt_sec, cnt_ded, exp_sec, exp_ded);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid  = (sent < n) && ($urandom_range(0, 4) != 0);
            bus.in_code   = gen_code();
            correct_en    = 1'($urandom);
            #1;
            checks++;
            if (bus.in_ready !== (!bus.out_valid || bus.out_ready)) begin
                errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", cyc, bus.in_ready, !bus.out_valid || bus.out_ready);
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra_word got=%0h exp=none", bus.out_data);
                end else begin
                    e = q.pop_front();
                    if ({bus.out_data, bus.out_sec, bus.out_ded, bus.out_err_pos} !== {e.data, e.sec, e.ded, e.pos}) begin
                        errors++;
                        $display("FAIL rand_word%0d got data=%0h sec=%b ded=%b pos=%0d exp data=%0h sec=%b ded=%b pos=%0d", got,
                                 bus.out_data, bus.out_sec, bus.out_ded, bus.out_err_pos, e.data, e.sec, e.ded, e.pos);
                    end
                    exp_sec += int'(e.sec);
                    exp_ded += int'(e.ded);
                end
                got++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(model(bus.in_code, correct_en));
                sent++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        checks++;
        if (got !== n) begin errors++; $display("FAIL rand_delivered got=%0d exp=%0d", got, n); end
        @(negedge clk);
        checks++;
        if (cnt_sec !== 16'(exp_sec) || cnt_ded !== 16'(exp_ded)) begin
            errors++; $display("FAIL rand_final_counters got sec=%0d ded=%0d exp sec=%0d ded=%0d", cnt_sec, cnt_ded, exp_sec, exp_ded);
        end
    endtask

    task automatic test_saturation();
        int w;
        bus2.out_ready = 1'b1;
        correct_en2    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_code  = enc(8'($urandom)) ^ (13'(1) << $urandom_range(0, 12));
            bus2.in_valid = 1'b1;
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (cnt_sec2 !== 2'd3) begin errors++; $display("FAIL sat_cnt_sec got=%0d exp=3", cnt_sec2); end
        checks++;
        if (cnt_ded2 !== 2'd0) begin errors++; $display("FAIL sat_cnt_ded got=%0d exp=0", cnt_ded2); end
        @(negedge clk);
        bus2.in_code  = enc(8'($urandom)) ^ 13'h0020;
        bus2.in_valid = 1'b1;
        @(negedge clk);
        bus2.in_valid = 1'b0;
        w = 0;
        while (!bus2.out_valid && w < 8) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (bus2.out_valid !== 1'b1 || bus2.out_sec !== 1'b1) begin
            errors++; $display("FAIL sat_clr_word got valid=%b sec=%b exp valid=1 sec=1", bus2.out_valid, bus2.out_sec);
        end
        clr_cnt2 = 1'b1;
        @(negedge clk);
        clr_cnt2 = 1'b0;
        checks++;
        if (cnt_sec2 !== 2'd0) begin errors++; $display("FAIL sat_clr_wins got=%0d exp=0", cnt_sec2); end
    endtask

    task automatic test_reset_midflight();
        logic [14:0] outs;
        @(negedge clk);
        bus.out_ready = 1'b1;
        correct_en    = 1'b1;
        bus.in_code   = enc(8'($urandom)) ^ 13'h0008;
        bus.in_valid  = 1'b1;
        @(negedge clk);
        bus.in_code   = enc(8'($urandom)) ^ 13'h0101;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midflight_setup got=%b exp=1", bus.out_valid); end
        reset = 1'b0;
        #1;
        outs = {bus.out_valid, bus.out_sec, bus.out_ded, bus.out_err_pos, bus.out_data};
        checks++;
        if (outs !== 15'd0) begin errors++; $display("FAIL midflight_outputs got=%0h exp=0", outs); end
        checks++;
        if ({cnt_sec, cnt_ded} !== 32'd0) begin errors++; $display("FAIL midflight_counters got=%0h exp=0", {cnt_sec, cnt_ded}); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midflight_in_ready got=%b exp=1", bus.in_ready); end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midflight_dropped got=%b exp=0", bus.out_valid); end
        end
        checks++;
        if ({cnt_sec, cnt_ded} !== 32'd0) begin errors++; $display("FAIL midflight_not_counted got=%0h exp=0", {cnt_sec, cnt_ded}); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_stall();
        test_random(300);
        test_saturation();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
